ram_slot_arbiter: RTL and testbench
===================================

// Module: ram_slot_arbiter
//
// PURPOSE
// - Generates the CPU clock enable (RDY) and phi2, and shares the single block-RAM port
//   between the 65C02 and a secondary DMA requester.
// - Uses time-slot multiplexing. CPU-owned phases are fixed; DMA gets the remaining phases.
// - Stretches CPU cycles that target the external bus by a programmable number of wait periods.
// - Sits between the CPU core, the RAM array and the address decode in the top level.
//
// PARAMETERS
// - CLKEN_DIV      4   clk cycles per CPU cycle; must be >= 3
// - EXT_WAIT       2   extra CPU periods added to an external-bus cycle; range 0..15, 0 = none
// - RAM_ADDR_BITS  15  RAM address width
//
// PORTS
// - clk          in   1   system clock
// - reset        in   1   synchronous, active-high reset
// - cpu_addr     in   16  registered CPU address (current bus cycle)
// - cpu_we       in   1   registered CPU write enable
// - cpu_dout     in   8   registered CPU write data
// - cpu_ram_sel  in   1   current cycle decodes to RAM
// - cpu_ext_sel  in   1   current cycle decodes to the external bus
// - cpu_clken    out  1   CPU RDY / clock enable, one clk wide
// - phi2         out  1   external bus phase-2 clock
// - dma_req      in   1   DMA access valid; addr/we/wdata stable while high
// - dma_we       in   1   DMA write (1) / read (0)
// - dma_addr     in   RAM_ADDR_BITS  DMA RAM address
// - dma_wdata    in   8   DMA write data
// - dma_gnt      out  1   access accepted this cycle (comb.: req && free slot)
// - dma_rvalid   out  1   read data valid; one clk after a read grant
// - dma_rdata    out  8   read data, held until next rvalid
// - ram_addr     out  RAM_ADDR_BITS  RAM port address
// - ram_we       out  1   RAM port write strobe
// - ram_wdata    out  8   RAM port write data
// - ram_rdata    in   8   RAM read data, registered (1 clk latency)
//
// BEHAVIOUR
// Phase counter
// - phase counts 0..CLKEN_DIV-1 and wraps. Power-up value is 0.
// - phase is NOT cleared by reset; it runs free so the CPU keeps clocking during reset.
//
// State machine (RUN / WAIT) and wait counter
// - RUN, phase==DIV-1:
//   - cpu_ext_sel=0 or EXT_WAIT=0: cpu_clken=1.
//   - Otherwise: cpu_clken=0, go to WAIT, wcnt<=EXT_WAIT-1.
// - WAIT, phase==DIV-1:
//   - wcnt==0: cpu_clken=1, go to RUN.
//   - Otherwise: wcnt<=wcnt-1.
// - cpu_clken is never asserted at any other phase.
// - cpu_clken keeps pulsing while reset is high.
//
// phi2
// - phi2 = (phase >= DIV/2) || (state==WAIT).
// - phi2 is held high across the whole stretch.
//
// Slot ownership
// - CPU owns phases DIV-2 and DIV-1 in RUN. These are the read-setup and clken cycles.
// - All other phases are free.
// - In WAIT, every phase is free; cpu_addr is not a RAM address then.
// - dma_gnt = dma_req && free && !reset.
//
// RAM port
// - ram_addr = dma_gnt ? dma_addr : cpu_addr[RAM_ADDR_BITS-1:0].
// - ram_wdata = dma_gnt ? dma_wdata : cpu_dout.
// - ram_we = (dma_gnt && dma_we) || (cpu_clken && cpu_we && cpu_ram_sel).
// - Both write sources can never be active in the same clk.
//
// DMA handshake
// - Transfer occurs in the gnt cycle.
// - Read: dma_rvalid=1 in the next clk, with dma_rdata<=ram_rdata.
// - Write: no rvalid.
// - If req stays high after gnt, it is a new request and is granted at the next free phase.
//   A grant is therefore possible on consecutive free clks.
// - While req is high and the phase is CPU-owned, gnt=0; the requester holds its request.
//
// Reset (sync)
// - state<=RUN, wcnt<=0, dma_rvalid<=0, dma_rdata<=0, dma_gnt=0.
// - A rvalid due in the reset cycle is dropped.
// - Reset during WAIT aborts the stretch. The next phase DIV-1 fires cpu_clken normally,
//   provided cpu_ext_sel is low.
//
// TESTING (DIV=4, EXT_WAIT=2 unless noted)
// 1. Idle after reset:
//    - cpu_clken=1 at phase 3 only, phi2 pattern 0,0,1,1, dma_gnt=0.
//    - cpu_clken keeps pulsing while reset is held.
// 2. DMA read of 0x1234 (preload 0xA5), req at phase 2:
//    - gnt waits to phase 0, ram_addr=0x1234.
//    - rvalid at phase 1 with rdata=0xA5.
//    - req held -> second gnt at phase 1, rvalid at phase 2.
// 3. Same period: CPU writes 0x55 to 0x0010 and DMA writes 0xAA to 0x0011:
//    - ram_we at phase 0 (DMA) and phase 3 (CPU).
//    - Both locations read back correctly.
// 4. cpu_ext_sel=1 at phase 3:
//    - clken suppressed for 2 periods, fires on the 3rd phase 3.
//    - phi2 high for 10 consecutive clks.
//    - dma_req held high is granted on every clk in WAIT.
// 5. Reset pulse for 1 clk in WAIT, with a read gnt in the prior clk:
//    - rvalid is suppressed, state returns to RUN, clken fires at the next phase 3.
// 6. EXT_WAIT=0, cpu_ext_sel=1:
//    - clken every 4 clks, no phi2 stretch, DMA slots only at phases 0 and 1.

Source files
------------

// File: rtl/ram_slot_arbiter_if.sv
// Bus bundle between the RAM slot arbiter and its CPU, DMA and RAM neighbours.
// The arbiter takes the slave side; the top level (or a bench) takes the master side.
interface ram_slot_arbiter_if #(
  parameter int RAM_ADDR_BITS = 15
);
  logic [15:0]              cpu_addr;
  logic                     cpu_we;
  logic [7:0]               cpu_dout;
  logic                     cpu_ram_sel;
  logic                     cpu_ext_sel;
  logic                     cpu_clken;
  logic                     phi2;

  logic                     dma_req;
  logic                     dma_we;
  logic [RAM_ADDR_BITS-1:0] dma_addr;
  logic [7:0]               dma_wdata;
  logic                     dma_gnt;
  logic                     dma_rvalid;
  logic [7:0]               dma_rdata;

  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic                     ram_we;
  logic [7:0]               ram_wdata;
  logic [7:0]               ram_rdata;

  modport slave (
    input  cpu_addr, cpu_we, cpu_dout, cpu_ram_sel, cpu_ext_sel,
    output cpu_clken, phi2,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_addr, cpu_we, cpu_dout, cpu_ram_sel, cpu_ext_sel,
    input  cpu_clken, phi2,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_slot_arbiter.sv
// CPU clock-enable/phi2 generator and time-slot arbiter for the shared block-RAM port.
// state  | meaning
// S_RUN  | normal CPU cycle; CPU owns the last two phases
// S_WAIT | external-bus stretch; every phase free for DMA, phi2 held high
module ram_slot_arbiter #(
  parameter int CLKEN_DIV     = 4,
  parameter int EXT_WAIT      = 2,
  parameter int RAM_ADDR_BITS = 15
) (
  input logic               clk,
  input logic               reset,
  ram_slot_arbiter_if.slave bus
);
  localparam int PW = $clog2(CLKEN_DIV);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKEN_DIV - 1);
  localparam logic [PW-1:0] PH_CPU    = PW'(CLKEN_DIV - 2);
  localparam logic [PW-1:0] PH_HALF   = PW'(CLKEN_DIV / 2);
  localparam logic [3:0]    WAIT_LOAD = 4'((EXT_WAIT > 0) ? EXT_WAIT - 1 : 0);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic [PW-1:0] phase = '0;
  logic          clken;
  logic          free;
  logic          gnt;
  logic          rvalid_q;
  logic [7:0]    rdata_q;
  logic          unused_addr_hi;

  // Free-running so the CPU keeps being clocked through reset.
  always_ff @(posedge clk) begin
    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    clken     = 1'b0;
    if (phase == PH_LAST) begin
      case (state)
        S_RUN: begin
          if (!bus.cpu_ext_sel || (EXT_WAIT == 0)) begin
            clken = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) begin
            clken     = 1'b1;
            state_nxt = S_RUN;
          end else begin
            wcnt_nxt = wcnt - 4'd1;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  assign free = (state == S_WAIT) || (phase < PH_CPU);
  assign gnt  = bus.dma_req && free && !reset;

  assign bus.cpu_clken = clken;
  assign bus.phi2      = (phase >= PH_HALF) || (state == S_WAIT);
  assign bus.dma_gnt   = gnt;

  assign bus.ram_addr  = gnt ? bus.dma_addr  : bus.cpu_addr[RAM_ADDR_BITS-1:0];
  assign bus.ram_wdata = gnt ? bus.dma_wdata : bus.cpu_dout;
  assign bus.ram_we    = (gnt && bus.dma_we) || (clken && bus.cpu_we && bus.cpu_ram_sel);

  // RAM output is already registered, so read data is passed straight through
  // in the rvalid cycle and a copy is kept for the hold period.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      rvalid_q <= gnt && !bus.dma_we;
      if (bus.dma_rvalid) rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.dma_rvalid = rvalid_q && !reset;
  assign bus.dma_rdata  = bus.dma_rvalid ? bus.ram_rdata : rdata_q;

  assign unused_addr_hi = ^bus.cpu_addr[15:RAM_ADDR_BITS];
endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Self-checking bench for ram_slot_arbiter: directed scenarios plus a randomized run
// against a time-based reference model. A second instance covers EXT_WAIT=0.
module tb_ram_slot_arbiter;
  localparam int DIV = 4;
  localparam int W   = 2;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_slot_arbiter_if #(.RAM_ADDR_BITS(15)) a ();
  ram_slot_arbiter_if #(.RAM_ADDR_BITS(15)) b ();

  ram_slot_arbiter #(.CLKEN_DIV(DIV), .EXT_WAIT(W), .RAM_ADDR_BITS(15)) dut_a (
    .clk(clk), .reset(reset_a), .bus(a.slave));
  ram_slot_arbiter #(.CLKEN_DIV(DIV), .EXT_WAIT(0), .RAM_ADDR_BITS(15)) dut_b (
    .clk(clk), .reset(reset_b), .bus(b.slave));

  bit [7:0] mem [0:32767];
  always @(posedge clk) begin
    if (a.ram_we) mem[a.ram_addr] <= a.ram_wdata;
    a.ram_rdata <= mem[a.ram_addr];
  end
  assign b.ram_rdata = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    tick();
    for (int i = 0; i < DIV && (cyc % DIV) != p; i++) tick();
  endtask

  task automatic test_reset();
    int ph;
    a.dma_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      ph = cyc % DIV;
      n_checks++; if (a.cpu_clken !== (ph == 3)) begin n_fail++; $display("FAIL reset_clken ph%0d: got %b want %b", ph, a.cpu_clken, (ph == 3)); end
      n_checks++; if (a.phi2 !== (ph >= 2)) begin n_fail++; $display("FAIL reset_phi2 ph%0d: got %b want %b", ph, a.phi2, (ph >= 2)); end
      n_checks++; if (a.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt ph%0d: got %b want 0", ph, a.dma_gnt); end
    end
    tick();
    reset_a = 1'b0; reset_b = 1'b0; a.dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      #1;
      ph = cyc % DIV;
      n_checks++; if (a.cpu_clken !== (ph == 3)) begin n_fail++; $display("FAIL idle_clken ph%0d: got %b want %b", ph, a.cpu_clken, (ph == 3)); end
      n_checks++; if (a.phi2 !== (ph >= 2)) begin n_fail++; $display("FAIL idle_phi2 ph%0d: got %b want %b", ph, a.phi2, (ph >= 2)); end
      n_checks++; if (a.dma_gnt !== 1'b0 || a.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_dma ph%0d: gnt %b rvalid %b want 0 0", ph, a.dma_gnt, a.dma_rvalid); end
    end
  endtask

  task automatic test_dma_read();
    wait_phase(0);
    a.dma_req = 1'b1; a.dma_we = 1'b1; a.dma_addr = 15'h1234; a.dma_wdata = 8'hA5;
    #1;
    n_checks++; if (a.dma_gnt !== 1'b1 || a.ram_we !== 1'b1 || a.ram_addr !== 15'h1234) begin n_fail++; $display("FAIL preload_write: gnt %b we %b addr %h want 1 1 1234", a.dma_gnt, a.ram_we, a.ram_addr); end
    tick(); a.dma_req = 1'b0;
    wait_phase(2);
    a.dma_req = 1'b1; a.dma_we = 1'b0;
    #1;
    n_checks++; if (a.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL read_gnt_ph2: got %b want 0", a.dma_gnt); end
    tick(); #1;
    n_checks++; if (a.dma_gnt !== 1'b0 || a.cpu_clken !== 1'b1) begin n_fail++; $display("FAIL read_ph3: gnt %b clken %b want 0 1", a.dma_gnt, a.cpu_clken); end
    tick(); #1;
    n_checks++; if (a.dma_gnt !== 1'b1 || a.ram_addr !== 15'h1234 || a.ram_we !== 1'b0) begin n_fail++; $display("FAIL read_gnt_ph0: gnt %b addr %h we %b want 1 1234 0", a.dma_gnt, a.ram_addr, a.ram_we); end
    tick(); #1;
    n_checks++; if (a.dma_rvalid !== 1'b1 || a.dma_rdata !== 8'hA5 || a.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL read_ph1: rvalid %b rdata %h gnt %b want 1 a5 1", a.dma_rvalid, a.dma_rdata, a.dma_gnt); end
    tick(); a.dma_req = 1'b0; #1;
    n_checks++; if (a.dma_rvalid !== 1'b1 || a.dma_rdata !== 8'hA5) begin n_fail++; $display("FAIL read2_ph2: rvalid %b rdata %h want 1 a5", a.dma_rvalid, a.dma_rdata); end
    tick(); #1;
    n_checks++; if (a.dma_rvalid !== 1'b0 || a.dma_rdata !== 8'hA5) begin n_fail++; $display("FAIL read_hold: rvalid %b rdata %h want 0 a5", a.dma_rvalid, a.dma_rdata); end
  endtask

  task automatic test_same_period();
    wait_phase(0);
    a.cpu_addr = 16'h0010; a.cpu_we = 1'b1; a.cpu_dout = 8'h55; a.cpu_ram_sel = 1'b1; a.cpu_ext_sel = 1'b0;
    a.dma_req = 1'b1; a.dma_we = 1'b1; a.dma_addr = 15'h0011; a.dma_wdata = 8'hAA;
    #1;
    n_checks++; if (a.ram_we !== 1'b1 || a.ram_addr !== 15'h0011 || a.ram_wdata !== 8'hAA) begin n_fail++; $display("FAIL wr_dma_ph0: we %b addr %h data %h want 1 0011 aa", a.ram_we, a.ram_addr, a.ram_wdata); end
    tick(); a.dma_req = 1'b0; #1;
    n_checks++; if (a.ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_ph1: we %b want 0", a.ram_we); end
    tick(); #1;
    n_checks++; if (a.ram_we !== 1'b0 || a.ram_addr !== 15'h0010) begin n_fail++; $display("FAIL wr_ph2: we %b addr %h want 0 0010", a.ram_we, a.ram_addr); end
    tick(); #1;
    n_checks++; if (a.ram_we !== 1'b1 || a.cpu_clken !== 1'b1 || a.ram_addr !== 15'h0010 || a.ram_wdata !== 8'h55) begin n_fail++; $display("FAIL wr_cpu_ph3: we %b clken %b addr %h data %h want 1 1 0010 55", a.ram_we, a.cpu_clken, a.ram_addr, a.ram_wdata); end
    tick();
    a.cpu_we = 1'b0; a.cpu_ram_sel = 1'b0;
    a.dma_req = 1'b1; a.dma_we = 1'b0; a.dma_addr = 15'h0010;
    #1;
    n_checks++; if (a.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rb_gnt0: got %b want 1", a.dma_gnt); end
    tick(); a.dma_addr = 15'h0011; #1;
    n_checks++; if (a.dma_rvalid !== 1'b1 || a.dma_rdata !== 8'h55) begin n_fail++; $display("FAIL rb_cpu_loc: rvalid %b rdata %h want 1 55", a.dma_rvalid, a.dma_rdata); end
    tick(); a.dma_req = 1'b0; #1;
    n_checks++; if (a.dma_rvalid !== 1'b1 || a.dma_rdata !== 8'hAA) begin n_fail++; $display("FAIL rb_dma_loc: rvalid %b rdata %h want 1 aa", a.dma_rvalid, a.dma_rdata); end
  endtask

  task automatic test_ext_stretch();
    wait_phase(0);
    a.cpu_ext_sel = 1'b1; a.cpu_ram_sel = 1'b0; a.cpu_we = 1'b0;
    a.dma_req = 1'b1; a.dma_we = 1'b0; a.dma_addr = 15'h1234;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) tick();
      #1;
      n_checks++; if (a.cpu_clken !== (i == 11)) begin n_fail++; $display("FAIL ext_clken clk%0d: got %b want %b", i, a.cpu_clken, (i == 11)); end
      n_checks++; if (a.phi2 !== (i >= 2)) begin n_fail++; $display("FAIL ext_phi2 clk%0d: got %b want %b", i, a.phi2, (i >= 2)); end
      n_checks++; if (a.dma_gnt !== !(i == 2 || i == 3)) begin n_fail++; $display("FAIL ext_gnt clk%0d: got %b want %b", i, a.dma_gnt, !(i == 2 || i == 3)); end
    end
    tick(); a.cpu_ext_sel = 1'b0; a.dma_req = 1'b0; #1;
    n_checks++; if (a.phi2 !== 1'b0 || a.cpu_clken !== 1'b0) begin n_fail++; $display("FAIL ext_end: phi2 %b clken %b want 0 0", a.phi2, a.cpu_clken); end
  endtask

  task automatic test_reset_in_wait();
    wait_phase(0);
    a.cpu_ext_sel = 1'b1; a.dma_req = 1'b0;
    wait_phase(3); #1;
    n_checks++; if (a.cpu_clken !== 1'b0) begin n_fail++; $display("FAIL riw_stretch: clken %b want 0", a.cpu_clken); end
    tick();
    a.dma_req = 1'b1; a.dma_we = 1'b0; a.dma_addr = 15'h0011;
    #1;
    n_checks++; if (a.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL riw_gnt: got %b want 1", a.dma_gnt); end
    tick(); reset_a = 1'b1; a.cpu_ext_sel = 1'b0; #1;
    n_checks++; if (a.dma_rvalid !== 1'b0 || a.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL riw_reset: rvalid %b gnt %b want 0 0", a.dma_rvalid, a.dma_gnt); end
    tick(); reset_a = 1'b0; #1;
    n_checks++; if (a.dma_gnt !== 1'b0 || a.dma_rvalid !== 1'b0 || a.dma_rdata !== 8'h00) begin n_fail++; $display("FAIL riw_run: gnt %b rvalid %b rdata %h want 0 0 00", a.dma_gnt, a.dma_rvalid, a.dma_rdata); end
    tick(); #1;
    n_checks++; if (a.cpu_clken !== 1'b1 || a.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL riw_clken: clken %b gnt %b want 1 0", a.cpu_clken, a.dma_gnt); end
    tick(); a.dma_req = 1'b0; #1;
    n_checks++; if (a.phi2 !== 1'b0) begin n_fail++; $display("FAIL riw_phi2: got %b want 0", a.phi2); end
  endtask

  task automatic test_no_wait();
    int ph;
    b.cpu_ext_sel = 1'b1; b.dma_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      ph = cyc % DIV;
      n_checks++; if (b.cpu_clken !== (ph == 3)) begin n_fail++; $display("FAIL nowait_clken ph%0d: got %b want %b", ph, b.cpu_clken, (ph == 3)); end
      n_checks++; if (b.phi2 !== (ph >= 2)) begin n_fail++; $display("FAIL nowait_phi2 ph%0d: got %b want %b", ph, b.phi2, (ph >= 2)); end
      n_checks++; if (b.dma_gnt !== (ph < 2)) begin n_fail++; $display("FAIL nowait_gnt ph%0d: got %b want %b", ph, b.dma_gnt, (ph < 2)); end
    end
    b.dma_req = 1'b0;
  endtask

  task automatic test_random();
    int st_start = -2, st_end = -1, ph;
    bit stretching, pend_v = 0, held_known = 0, last_clken = 1, last_gnt = 0;
    bit e_clken, e_phi2, e_gnt, e_we, e_rv;
    logic [7:0] pend_d = 8'h00, held = 8'h00, e_wd, e_rd;
    logic [14:0] e_addr;
    logic [7:0] ref_mem [0:63];
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;
    a.cpu_ext_sel = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset_a = (n == 0) || ($urandom_range(63) == 0);
      if (last_clken) begin
        a.cpu_ext_sel = ($urandom_range(3) == 0);
        a.cpu_ram_sel = !a.cpu_ext_sel && $urandom_range(1) == 1;
        a.cpu_we      = $urandom_range(1) == 1;
        a.cpu_addr    = 16'h4000 | 16'($urandom_range(63));
        a.cpu_dout    = 8'($urandom);
      end
      if (!(a.dma_req && !last_gnt)) begin
        a.dma_req   = $urandom_range(1) == 1;
        a.dma_we    = $urandom_range(1) == 1;
        a.dma_addr  = 15'h4000 | 15'($urandom_range(63));
        a.dma_wdata = 8'($urandom);
      end
      #1;
      ph = cyc % DIV;
      stretching = (st_start < cyc) && (cyc <= st_end);
      e_clken = (ph == DIV - 1) && (stretching ? (cyc == st_end) : !(a.cpu_ext_sel && W > 0));
      e_phi2  = (ph >= DIV / 2) || stretching;
      e_gnt   = a.dma_req && (stretching || ph < DIV - 2) && !reset_a;
      e_we    = (e_gnt && a.dma_we) || (e_clken && a.cpu_we && a.cpu_ram_sel);
      e_addr  = e_gnt ? a.dma_addr : a.cpu_addr[14:0];
      e_wd    = e_gnt ? a.dma_wdata : a.cpu_dout;
      e_rv    = pend_v && !reset_a;
      e_rd    = e_rv ? pend_d : held;
      n_checks++; if (a.cpu_clken !== e_clken) begin n_fail++; $display("FAIL rnd_clken n%0d: got %b want %b", n, a.cpu_clken, e_clken); end
      n_checks++; if (a.phi2 !== e_phi2) begin n_fail++; $display("FAIL rnd_phi2 n%0d: got %b want %b", n, a.phi2, e_phi2); end
      n_checks++; if (a.dma_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt n%0d: got %b want %b", n, a.dma_gnt, e_gnt); end
      n_checks++; if (a.ram_we !== e_we || a.ram_addr !== e_addr || a.ram_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_ram n%0d: we %b addr %h data %h want %b %h %h", n, a.ram_we, a.ram_addr, a.ram_wdata, e_we, e_addr, e_wd); end
      n_checks++; if (a.dma_rvalid !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid n%0d: got %b want %b", n, a.dma_rvalid, e_rv); end
      if (e_rv || held_known) begin
        n_checks++; if (a.dma_rdata !== e_rd) begin n_fail++; $display("FAIL rnd_rdata n%0d: got %h want %h", n, a.dma_rdata, e_rd); end
      end
      if (e_rv) held = pend_d;
      if (reset_a) begin held = 8'h00; held_known = 1; end
      pend_v = e_gnt && !a.dma_we;
      pend_d = ref_mem[a.dma_addr[5:0]];
      if (e_we) ref_mem[e_addr[5:0]] = e_wd;
      if (reset_a) begin
        st_start = -2; st_end = -1;
      end else if (!stretching && ph == DIV - 1 && a.cpu_ext_sel && W > 0) begin
        st_start = cyc; st_end = cyc + W * DIV;
      end
      last_clken = e_clken;
      last_gnt   = e_gnt;
    end
    reset_a = 1'b0;
    a.dma_req = 1'b0;
  endtask

  initial begin
    a.cpu_addr = 16'h0000; a.cpu_we = 1'b0; a.cpu_dout = 8'h00; a.cpu_ram_sel = 1'b0; a.cpu_ext_sel = 1'b0;
    a.dma_req = 1'b0; a.dma_we = 1'b0; a.dma_addr = 15'h0000; a.dma_wdata = 8'h00;
    b.cpu_addr = 16'h0000; b.cpu_we = 1'b0; b.cpu_dout = 8'h00; b.cpu_ram_sel = 1'b0; b.cpu_ext_sel = 1'b0;
    b.dma_req = 1'b0; b.dma_we = 1'b0; b.dma_addr = 15'h0000; b.dma_wdata = 8'h00;
    test_reset();
    test_dma_read();
    test_same_period();
    test_ext_stretch();
    test_reset_in_wait();
    test_no_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end
endmodule
